// File: rtl/timer_device_if.sv
// Bus bundle between the system bridge and the countdown timer:
// word select, write strobe, write data, read data and the interrupt line.
interface timer_device_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    // Bridge / CPU side: drives the bus, observes read data and interrupt.
    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    // Timer side: receives the bus, returns read data and interrupt.
    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Word map: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only), 3 reads 0.
// The interrupt output is a flop fed from the next-state pending and IM values,
// so the bus write strobe never reaches irq combinationally.
module timer_device #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    timer_device_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_ctrl;
    logic [CNT_W-1:0]   r_preset;
    logic [CNT_W-1:0]   r_count;
    logic               r_pending;
    logic               r_irq;

    logic               w_wr_ctrl;
    logic               w_wr_preset;
    logic               w_en;
    logic               w_auto_reload;
    logic               w_load;
    logic               w_dec;
    logic               w_set_pend;
    logic               w_int_clr;
    logic               w_fsm_clr_en;
    logic               w_pend_nxt;
    logic               w_im_nxt;
    logic [31:0]        w_preset_ext;
    logic [31:0]        w_count_ext;
    logic [31:0]        w_rdata;

    assign w_wr_ctrl     = bus.we && (bus.addr == 2'd0);
    assign w_wr_preset   = bus.we && (bus.addr == 2'd1);
    assign w_en          = r_ctrl[0];
    // Only MODE == 01 reloads; 00 and 1x both behave as one-shot.
    assign w_auto_reload = (r_ctrl[2:1] == 2'b01);

    // Next-state and per-state control strobes for the countdown FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_set_pend   = 1'b0;
        w_int_clr    = 1'b0;
        w_fsm_clr_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == {CNT_W{1'b0}}) begin
                    w_set_pend  = 1'b1;
                    w_state_nxt = S_INT;
                end else begin
                    w_dec       = 1'b1;
                    w_state_nxt = S_CNT;
                end
            end
            S_INT: begin
                if (w_auto_reload) begin
                    w_int_clr   = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_fsm_clr_en = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // CTRL register: a bus write beats the FSM's own EN clear at the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ctrl <= 4'd0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= bus.wdata[3:0];
        end else if (w_fsm_clr_en) begin
            r_ctrl[0] <= 1'b0;
        end else begin
            r_ctrl <= r_ctrl;
        end
    end

    // PRESET register; a running count only sees a new value at the next LOAD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_preset <= {CNT_W{1'b0}};
        end else if (w_wr_preset) begin
            r_preset <= bus.wdata[CNT_W-1:0];
        end else begin
            r_preset <= r_preset;
        end
    end

    // COUNT register: load from PRESET, or decrement while non-zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_count <= r_preset;
        end else if (w_dec) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Pending next value: expiry wins over a clearing write so no interrupt is lost.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_set_pend) begin
            w_pend_nxt = 1'b1;
        end else if (w_wr_ctrl || w_wr_preset || w_int_clr) begin
            w_pend_nxt = 1'b0;
        end else begin
            w_pend_nxt = r_pending;
        end
    end

    assign w_im_nxt = w_wr_ctrl ? bus.wdata[3] : r_ctrl[3];

    // Pending flag and masked interrupt output, both updated at the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_irq     <= w_pend_nxt & w_im_nxt;
        end
    end

    // Read mux: narrow registers are zero-extended to the 32-bit bus.
    always_comb begin
        w_preset_ext              = 32'd0;
        w_preset_ext[CNT_W-1:0]   = r_preset;
        w_count_ext               = 32'd0;
        w_count_ext[CNT_W-1:0]    = r_count;
        case (bus.addr)
            2'd0:    w_rdata = {28'd0, r_ctrl};
            2'd1:    w_rdata = w_preset_ext;
            2'd2:    w_rdata = w_count_ext;
            default: w_rdata = 32'd0;
        endcase
    end

    assign bus.rdata = w_rdata;
    assign bus.irq   = r_irq;

endmodule

// File: tb/tb_timer_device.sv
// Scoreboard bench for timer_device: a driver issues bus cycles at the falling
// edge and pushes the reference model's expected post-edge view; a monitor pops
// and compares shortly after each rising edge.
module tb_timer_device;

    logic clk;
    logic reset;
    timer_device_if bus_if ();

    timer_device #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic [31:0] rdata;
        logic [1:0]  addr;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_id   = 0;

    // Reference model: architectural state after the most recently issued edge.
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;
    int          m_phase;
    bit          m_en;
    bit   [1:0]  m_mode;
    bit          m_im;
    bit   [31:0] m_preset;
    bit   [31:0] m_count;
    bit          m_pend;

    // Applies one rising edge of the timer rules to the model.
    task automatic model_step(input bit rst, input bit we, input bit [1:0] a, input bit [31:0] d);
        int         ph;
        bit         en;
        bit  [31:0] cnt;
        bit         pend;
        bit         reload;
        if (!rst) begin
            m_phase = PH_IDLE; m_en = 0; m_mode = 0; m_im = 0;
            m_preset = 0; m_count = 0; m_pend = 0;
        end else begin
            reload = (m_mode == 2'b01);
            ph = m_phase; en = m_en; cnt = m_count; pend = m_pend;
            if (m_phase == PH_IDLE) begin
                if (m_en) ph = PH_LOAD;
            end else if (m_phase == PH_LOAD) begin
                cnt = m_preset; ph = PH_CNT;
            end else if (m_phase == PH_CNT) begin
                if (!m_en) ph = PH_IDLE;
                else if (m_count == 0) ph = PH_INT;
                else cnt = m_count - 1;
            end else begin
                if (reload) ph = PH_LOAD;
                else begin ph = PH_IDLE; en = 0; end
            end
            if (m_phase == PH_CNT && m_en && m_count == 0) pend = 1;
            else if (we && a < 2) pend = 0;
            else if (m_phase == PH_INT && reload) pend = 0;
            if (we && a == 2'd0) begin
                m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
            end else begin
                m_en = en;
            end
            if (we && a == 2'd1) m_preset = d;
            m_phase = ph; m_count = cnt; m_pend = pend;
        end
    endtask

    // One bus cycle: drive at the falling edge, update model, queue expectation.
    task automatic cycle(input bit rst, input bit we, input bit [1:0] a, input bit [31:0] d);
        exp_t e;
        @(negedge clk);
        reset = rst; bus_if.we = we; bus_if.addr = a; bus_if.wdata = d;
        model_step(rst, we, a, d);
        e.irq = m_pend & m_im;
        case (a)
            2'd0:    e.rdata = {28'd0, m_im, m_mode, m_en};
            2'd1:    e.rdata = m_preset;
            2'd2:    e.rdata = m_count;
            default: e.rdata = 32'd0;
        endcase
        e.addr = a;
        e.id = n_id;
        n_id++;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit [1:0] a);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, a, 32'd0);
    endtask

    // Monitor: compares DUT outputs against queued expectations after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (bus_if.irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL irq cyc=%0d got=%b exp=%b", e.id, bus_if.irq, e.irq);
                end
                n_cmp++;
                if (bus_if.rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL rdata cyc=%0d addr=%0d got=%h exp=%h",
                             e.id, e.addr, bus_if.rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        int          guard;
        bit          we;
        bit   [1:0]  a;
        bit   [31:0] d;
        reset = 1'b0; bus_if.we = 1'b0; bus_if.addr = 2'd0; bus_if.wdata = 32'd0;
        m_phase = PH_IDLE; m_en = 0; m_mode = 0; m_im = 0;
        m_preset = 0; m_count = 0; m_pend = 0;

        // Reset state at each readable word.
        cycle(1'b0, 1'b0, 2'd0, 32'd0);
        cycle(1'b0, 1'b0, 2'd1, 32'd0);
        cycle(1'b0, 1'b0, 2'd2, 32'd0);
        idle(1, 2'd3);

        // One-shot with IM: countdown, expiry, EN self-clear, clear by CTRL write.
        cycle(1'b1, 1'b1, 2'd1, 32'd5);
        cycle(1'b1, 1'b1, 2'd0, 32'h9);
        idle(9, 2'd2);
        idle(3, 2'd0);
        cycle(1'b1, 1'b1, 2'd0, 32'h8);
        idle(2, 2'd0);

        // Auto-reload: periodic single-cycle pulses.
        cycle(1'b1, 1'b1, 2'd1, 32'd3);
        cycle(1'b1, 1'b1, 2'd0, 32'hB);
        idle(26, 2'd2);
        cycle(1'b1, 1'b1, 2'd0, 32'h0);
        idle(2, 2'd2);

        // Disable freezes COUNT, re-enable reloads from PRESET.
        cycle(1'b1, 1'b1, 2'd1, 32'd10);
        cycle(1'b1, 1'b1, 2'd0, 32'h9);
        idle(6, 2'd2);
        cycle(1'b1, 1'b1, 2'd0, 32'h8);
        idle(3, 2'd2);
        cycle(1'b1, 1'b1, 2'd1, 32'd4);
        cycle(1'b1, 1'b1, 2'd0, 32'h9);
        idle(4, 2'd2);
        cycle(1'b1, 1'b1, 2'd0, 32'h0);

        // IM=0 masks irq; a later CTRL write clears pending before it is exposed.
        cycle(1'b1, 1'b1, 2'd1, 32'd2);
        cycle(1'b1, 1'b1, 2'd0, 32'h1);
        idle(8, 2'd2);
        cycle(1'b1, 1'b1, 2'd0, 32'h8);
        idle(3, 2'd0);

        // Reset in the middle of a count.
        cycle(1'b1, 1'b1, 2'd1, 32'd20);
        cycle(1'b1, 1'b1, 2'd0, 32'h9);
        guard = 0;
        while (!(m_phase == PH_CNT && m_count == 32'd7) && guard < 40) begin
            idle(1, 2'd2);
            guard++;
        end
        n_cmp++;
        if (guard >= 40) begin
            n_fail++;
            $display("FAIL reach_count7 got=timeout exp=count7");
        end
        cycle(1'b0, 1'b0, 2'd2, 32'd0);
        idle(1, 2'd0);
        idle(20, 2'd2);

        // Randomized traffic with biased small presets to provoke frequent expiries.
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 5) == 0);
            a  = 2'($urandom_range(0, 3));
            if (a == 2'd1) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
            else if (a == 2'd0) d = $urandom & 32'hFFFF_FFF1 | 32'($urandom_range(0, 15) < 12);
            else d = $urandom;
            if ($urandom_range(0, 199) == 0) cycle(1'b0, 1'b0, a, d);
            else cycle(1'b1, we, a, d);
        end
        idle(2, 2'd0);

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d exp=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
